// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operating-mode encoding.
package shift_reg_pkg;

    localparam int unsigned ModeWidth = 2;

    typedef enum logic [ModeWidth-1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit register stage of the universal shift register, with a 4-way next-value mux.
module shift_stage
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  mode_e            sel_i,
    input  logic [WIDTH-1:0] up_i,
    input  logic [WIDTH-1:0] down_i,
    input  logic [WIDTH-1:0] load_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_d, stage_q;

    always_comb begin
        stage_d = stage_q;
        unique case (sel_i)
            MODE_HOLD: stage_d = stage_q;
            MODE_UP:   stage_d = up_i;
            MODE_DOWN: stage_d = down_i;
            MODE_LOAD: stage_d = load_i;
        endcase
        // Clear wins over enable; enable gates every mode.
        if (clr_i) begin
            stage_d = '0;
        end else if (!en_i) begin
            stage_d = stage_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift-up / shift-down / parallel load with fill counter.
// Define SHIFT_REG_UNIV_ROTATE_EN to make shifts with rot=1 rotate instead of taking sin.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic                       clr,
    input  logic                       en,
    input  logic [ModeWidth-1:0]       mode,
    input  logic [WIDTH-1:0]           sin,
    input  logic                       rot,
    input  logic [DEPTH*WIDTH-1:0]     pdata,
    output logic [DEPTH*WIDTH-1:0]     pout,
    output logic [WIDTH-1:0]           sout_hi,
    output logic [WIDTH-1:0]           sout_lo,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    mode_e            mode_sel;
    logic             rot_eff;
    logic [WIDTH-1:0] up_in, down_in;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [CntW-1:0]  count_d, count_q;

    assign mode_sel = mode_e'(mode);

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    assign rot_eff = rot;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign rot_eff    = 1'b0;
`endif

    // Vacated end stage takes the outgoing stage when rotating, otherwise sin.
    assign up_in   = rot_eff ? stage_q[DEPTH-1] : sin;
    assign down_in = rot_eff ? stage_q[0]       : sin;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] up_src, down_src;

        if (k == 0) begin : g_lo
            assign up_src = up_in;
        end else begin : g_lo_mid
            assign up_src = stage_q[k-1];
        end

        if (k == DEPTH - 1) begin : g_hi
            assign down_src = down_in;
        end else begin : g_hi_mid
            assign down_src = stage_q[k+1];
        end

        shift_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i  (clk),
            .rst_ni (r),
            .clr_i  (clr),
            .en_i   (en),
            .sel_i  (mode_sel),
            .up_i   (up_src),
            .down_i (down_src),
            .load_i (pdata[k*WIDTH +: WIDTH]),
            .q_o    (stage_q[k])
        );

        assign pout[k*WIDTH +: WIDTH] = stage_q[k];
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            unique case (mode_sel)
                MODE_HOLD: count_d = count_q;
                MODE_UP, MODE_DOWN: begin
                    if (!rot_eff && (count_q != CntW'(DEPTH))) begin
                        count_d = count_q + CntW'(1);
                    end
                end
                MODE_LOAD: count_d = CntW'(DEPTH);
            endcase
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign full    = (count_q == CntW'(DEPTH));
    assign sout_hi = stage_q[DEPTH-1];
    assign sout_lo = stage_q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: WIDTH=1 and WIDTH=8 instances (DEPTH=4) against a packed-vector model.
module tb_shift_reg_univ;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    localparam bit RotEn = 1'b1;
`else
    localparam bit RotEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        r, clr, en, rot;
    logic [1:0]  mode;
    logic        sin1;
    logic [7:0]  sin8;
    logic [3:0]  pdata1, pout1;
    logic [31:0] pdata8, pout8;
    logic        sout_hi1, sout_lo1;
    logic [7:0]  sout_hi8, sout_lo8;
    logic [2:0]  count1, count8;
    logic        full1, full8;

    logic [3:0]  exp1;
    logic [31:0] exp8;
    int          expc;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          chk_on = 1'b0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .r(r), .clr(clr), .en(en), .mode(mode), .sin(sin1), .rot(rot),
        .pdata(pdata1), .pout(pout1), .sout_hi(sout_hi1), .sout_lo(sout_lo1),
        .count(count1), .full(full1)
    );

    shift_reg_univ #(.WIDTH(8), .DEPTH(4)) u_dut8 (
        .clk(clk), .r(r), .clr(clr), .en(en), .mode(mode), .sin(sin8), .rot(rot),
        .pdata(pdata8), .pout(pout8), .sout_hi(sout_hi8), .sout_lo(sout_lo8),
        .count(count8), .full(full8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the register file as one packed word; shifts are concatenations.
    task automatic model_update();
        bit ro;
        ro = RotEn && rot;
        if (!r || clr) begin
            exp1 = '0;
            exp8 = '0;
            expc = 0;
        end else if (en) begin
            case (mode)
                2'b01: begin
                    exp1 = {exp1[2:0], ro ? exp1[3] : sin1};
                    exp8 = {exp8[23:0], ro ? exp8[31:24] : sin8};
                    if (!ro) expc = (expc + 1 > 4) ? 4 : expc + 1;
                end
                2'b10: begin
                    exp1 = {ro ? exp1[0] : sin1, exp1[3:1]};
                    exp8 = {ro ? exp8[7:0] : sin8, exp8[31:8]};
                    if (!ro) expc = (expc + 1 > 4) ? 4 : expc + 1;
                end
                2'b11: begin
                    exp1 = pdata1;
                    exp8 = pdata8;
                    expc = 4;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pout1", pout1, exp1);
            chk("pout8", pout8, exp8);
            chk("count1", count1, expc);
            chk("count8", count8, expc);
            chk("full1", full1, expc == 4);
            chk("full8", full8, expc == 4);
            chk("sout_hi1", sout_hi1, exp1[3]);
            chk("sout_lo1", sout_lo1, exp1[0]);
            chk("sout_hi8", sout_hi8, exp8[31:24]);
            chk("sout_lo8", sout_lo8, exp8[7:0]);
        end
    end

    initial begin
        logic       s1v [4];
        logic [7:0] s8v [4];
        logic [3:0] rot_exp [4];
        s1v = '{1'b1, 1'b0, 1'b1, 1'b1};
        s8v = '{8'h11, 8'h22, 8'h33, 8'h44};
        if (RotEn) rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        else       rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};

        r = 1'b0; clr = 1'b0; en = 1'b0; rot = 1'b0; mode = 2'b00;
        sin1 = 1'b0; sin8 = '0; pdata1 = '0; pdata8 = '0;
        exp1 = '0; exp8 = '0; expc = 0;
        chk_on = 1'b1;

        repeat (2) cycle();
        chk("rst_pout8", pout8, 32'h0);
        chk("rst_count1", count1, 3'd0);
        chk("rst_full1", full1, 1'b0);
        @(negedge clk); #1 r = 1'b1;

        // Fill by shifting up
        en = 1'b1; mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            sin1 = s1v[i]; sin8 = s8v[i];
            cycle();
        end
        chk("up4_pout1", pout1, 4'b1011);
        chk("up4_count1", count1, 3'd4);
        chk("up4_full1", full1, 1'b1);
        chk("up4_pout8", pout8, 32'h11223344);
        sin1 = 1'b0; sin8 = 8'h00;
        cycle();
        chk("up5_pout1", pout1, 4'b0110);
        chk("up5_count1", count1, 3'd4);
        chk("up5_pout8", pout8, 32'h22334400);

        // Enable low, then hold mode
        en = 1'b0; sin1 = 1'b1; sin8 = 8'hFF;
        repeat (3) cycle();
        chk("en0_pout1", pout1, 4'b0110);
        chk("en0_count8", count8, 3'd4);
        en = 1'b1; mode = 2'b00;
        repeat (3) cycle();
        chk("hold_pout8", pout8, 32'h22334400);
        chk("hold_count8", count8, 3'd4);

        // Clear beats load
        clr = 1'b1; mode = 2'b11; pdata1 = 4'hF; pdata8 = 32'hFFFF_FFFF;
        cycle();
        clr = 1'b0;
        chk("clr_pout1", pout1, 4'b0000);
        chk("clr_pout8", pout8, 32'h0);
        chk("clr_count1", count1, 3'd0);

        mode = 2'b10; sin1 = 1'b1; sin8 = 8'hA5;
        cycle();
        chk("down1_count1", count1, 3'd1);
        chk("down1_full1", full1, 1'b0);
        chk("down1_pout1", pout1, 4'b1000);
        chk("down1_pout8", pout8, 32'hA500_0000);

        // Load then shift down
        mode = 2'b11; pdata8 = 32'hDEAD_BEEF; pdata1 = 4'b1010;
        cycle();
        chk("load_pout8", pout8, 32'hDEAD_BEEF);
        chk("load_count8", count8, 3'd4);
        mode = 2'b10; sin8 = 8'h00; sin1 = 1'b1;
        cycle();
        chk("dn_pout8", pout8, 32'h00DE_ADBE);
        chk("dn_sout_lo8", sout_lo8, 8'hBE);
        chk("dn_pout1", pout1, 4'b1101);

        // Asynchronous reset between edges
        #1 r = 1'b0;
        #1;
        chk("arst_pout8", pout8, 32'h0);
        chk("arst_pout1", pout1, 4'b0000);
        chk("arst_count8", count8, 3'd0);
        chk("arst_full8", full8, 1'b0);
        exp1 = '0; exp8 = '0; expc = 0;
        @(negedge clk); #1 r = 1'b1;
        mode = 2'b11; pdata1 = 4'b0110; pdata8 = 32'hCAFE_F00D;
        cycle();
        chk("post_rst_pout8", pout8, 32'hCAFE_F00D);
        chk("post_rst_count1", count1, 3'd4);

        // Rotate select
        pdata1 = 4'b0001; pdata8 = 32'h0102_0304;
        cycle();
        mode = 2'b01; rot = 1'b1; sin1 = 1'b0; sin8 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rot_pout1", pout1, rot_exp[i]);
            chk("rot_count1", count1, 3'd4);
        end

        clr = 1'b1; rot = 1'b0;
        cycle();
        clr = 1'b0; mode = 2'b01; sin1 = 1'b1; sin8 = 8'h80;
        cycle();
        rot = 1'b1; sin1 = 1'b0; sin8 = 8'h00;
        cycle();
        chk("rotp_pout1", pout1, 4'b0010);
        chk("rotp_count1", count1, RotEn ? 3'd1 : 3'd2);
        mode = 2'b10;
        cycle();
        chk("rotd_pout1", pout1, 4'b0001);
        chk("rotd_count8", count8, RotEn ? 3'd1 : 3'd3);
        rot = 1'b0; mode = 2'b00;
        cycle();

        @(negedge clk);
        #1 chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
